// File: rtl/traffic_light_monitor_pkg.sv
// Shared constants for the traffic light monitor: colour bit indices and
// one-hot encodings (common with the controller), monitor states and the
// fault-code values.
package traffic_light_monitor_pkg;

  localparam int unsigned RED_IDX    = 2;
  localparam int unsigned YELLOW_IDX = 1;
  localparam int unsigned GREEN_IDX  = 0;

  localparam logic [2:0] RYG_RED    = 3'b100;
  localparam logic [2:0] RYG_YELLOW = 3'b010;
  localparam logic [2:0] RYG_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_ARMING  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_e;

  localparam logic [2:0] FC_NONE          = 3'd0;
  localparam logic [2:0] FC_ILLEGAL       = 3'd1;
  localparam logic [2:0] FC_CONFLICT      = 3'd2;
  localparam logic [2:0] FC_BAD_SEQUENCE  = 3'd3;
  localparam logic [2:0] FC_SHORT_GREEN   = 3'd4;
  localparam logic [2:0] FC_SHORT_YELLOW  = 3'd5;
  localparam logic [2:0] FC_SHORT_ALL_RED = 3'd6;

  // Only R->G, G->Y and Y->R are legal colour changes.
  function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
    return ((from == RYG_RED)    && (to == RYG_GREEN))  ||
           ((from == RYG_GREEN)  && (to == RYG_YELLOW)) ||
           ((from == RYG_YELLOW) && (to == RYG_RED));
  endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_tracker.sv
// Per-road phase tracker: remembers the last sampled colour and how many
// consecutive samples it has been shown (saturating).
//   clk, reset     : clock, synchronous active-high reset
//   ryg            : current road light sample (R,Y,G)
//   changed        : current sample differs from the last one
//   prev_colour    : last sampled colour
//   prev_duration  : length of the phase ending with the last sample
//   one_hot_ok     : current sample is exactly one colour
module traffic_light_phase_tracker
  import traffic_light_monitor_pkg::*;
#(
  parameter int unsigned TIMER_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            ryg,
  output logic                  changed,
  output logic [2:0]            prev_colour,
  output logic [TIMER_BITS-1:0] prev_duration,
  output logic                  one_hot_ok
);

  logic [2:0]            last_colour_q, last_colour_d;
  logic [TIMER_BITS-1:0] count_q, count_d;

  always_comb begin
    changed       = (ryg != last_colour_q);
    prev_colour   = last_colour_q;
    prev_duration = count_q;
    one_hot_ok    = (ryg == RYG_RED) || (ryg == RYG_YELLOW) || (ryg == RYG_GREEN);

    last_colour_d = ryg;
    if (changed) begin
      count_d = TIMER_BITS'(1);
    end else if (count_q == '1) begin
      count_d = count_q;
    end else begin
      count_d = count_q + TIMER_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_colour_q <= RYG_RED;
      count_q       <= '0;
    end else begin
      last_colour_q <= last_colour_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor on the traffic light controller outputs. Latches the first
// violation (illegal pattern, conflict, bad sequence, short phases).
//   clk, reset               : clock, synchronous active-high reset
//   primaryRoadLight_RYG     : primary road lights (bit2 R, bit1 Y, bit0 G)
//   secondaryRoadLight_RYG   : secondary road lights
//   fault_clear              : leave FAULT back to ARMING
//   fault                    : latched violation flag
//   fault_code               : first violation code (0 = none)
//   fault_road               : road of first violation (0 primary, 1 secondary)
//   armed                    : high while monitoring
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int unsigned TIMER_BITS         = 16,
  parameter int unsigned MIN_GREEN_CYCLES   = 16,
  parameter int unsigned MIN_YELLOW_CYCLES  = 8,
  parameter int unsigned MIN_ALL_RED_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] primaryRoadLight_RYG,
  input  logic [2:0] secondaryRoadLight_RYG,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_road,
  output logic       armed
);

  localparam logic [TIMER_BITS-1:0] MIN_G  = TIMER_BITS'(MIN_GREEN_CYCLES);
  localparam logic [TIMER_BITS-1:0] MIN_Y  = TIMER_BITS'(MIN_YELLOW_CYCLES);
  localparam logic [TIMER_BITS-1:0] MIN_AR = TIMER_BITS'(MIN_ALL_RED_CYCLES);

  mon_state_e            state_q, state_d;
  logic [TIMER_BITS-1:0] all_red_q, all_red_d;
  logic                  fault_q, fault_d;
  logic [2:0]            code_q, code_d;
  logic                  road_q, road_d;

  logic                  p_changed, s_changed, p_ok, s_ok;
  logic [2:0]            p_prev, s_prev;
  logic [TIMER_BITS-1:0] p_dur, s_dur;

  traffic_light_phase_tracker #(.TIMER_BITS(TIMER_BITS)) u_primary (
    .clk           (clk),
    .reset         (reset),
    .ryg           (primaryRoadLight_RYG),
    .changed       (p_changed),
    .prev_colour   (p_prev),
    .prev_duration (p_dur),
    .one_hot_ok    (p_ok)
  );

  traffic_light_phase_tracker #(.TIMER_BITS(TIMER_BITS)) u_secondary (
    .clk           (clk),
    .reset         (reset),
    .ryg           (secondaryRoadLight_RYG),
    .changed       (s_changed),
    .prev_colour   (s_prev),
    .prev_duration (s_dur),
    .one_hot_ok    (s_ok)
  );

  // Lowest per-road code (conflict excluded); 0 when the road is clean.
  function automatic logic [2:0] road_code(
    input logic [2:0]            cur,
    input logic                  changed,
    input logic [2:0]            prev,
    input logic [TIMER_BITS-1:0] dur,
    input logic                  ok,
    input logic [TIMER_BITS-1:0] all_red
  );
    if (!ok)                                                        return FC_ILLEGAL;
    if (changed && !legal_step(prev, cur))                          return FC_BAD_SEQUENCE;
    if (changed && (prev == RYG_GREEN)  && (dur < MIN_G))           return FC_SHORT_GREEN;
    if (changed && (prev == RYG_YELLOW) && (dur < MIN_Y))           return FC_SHORT_YELLOW;
    if (changed && (prev == RYG_RED)    && (all_red < MIN_AR))      return FC_SHORT_ALL_RED;
    return FC_NONE;
  endfunction

  logic       both_red, conflict;
  logic [2:0] p_code, s_code, viol_code;
  logic       viol_road;

  always_comb begin
    both_red = (primaryRoadLight_RYG == RYG_RED) && (secondaryRoadLight_RYG == RYG_RED);
    conflict = (primaryRoadLight_RYG != RYG_RED) && (secondaryRoadLight_RYG != RYG_RED);
    p_code   = road_code(primaryRoadLight_RYG, p_changed, p_prev, p_dur, p_ok, all_red_q);
    s_code   = road_code(secondaryRoadLight_RYG, s_changed, s_prev, s_dur, s_ok, all_red_q);

    // Conflict (code 2) slots between the per-road illegal-pattern code and
    // the remaining per-road codes; primary wins ties.
    viol_code = FC_NONE;
    viol_road = 1'b0;
    if (p_code == FC_ILLEGAL) begin
      viol_code = FC_ILLEGAL;
    end else if (s_code == FC_ILLEGAL) begin
      viol_code = FC_ILLEGAL;
      viol_road = 1'b1;
    end else if (conflict) begin
      viol_code = FC_CONFLICT;
    end else if ((p_code != FC_NONE) && ((s_code == FC_NONE) || (p_code <= s_code))) begin
      viol_code = p_code;
    end else if (s_code != FC_NONE) begin
      viol_code = s_code;
      viol_road = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    road_d  = road_q;

    if (!both_red) begin
      all_red_d = '0;
    end else if (state_q == ST_ARMING) begin
      all_red_d = TIMER_BITS'(1);
    end else if (all_red_q == '1) begin
      all_red_d = all_red_q;
    end else begin
      all_red_d = all_red_q + TIMER_BITS'(1);
    end

    unique case (state_q)
      ST_ARMING: begin
        if (both_red) state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (viol_code != FC_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = viol_code;
          road_d  = viol_road;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d = ST_ARMING;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          road_d  = 1'b0;
        end
      end
      default: state_d = ST_ARMING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARMING;
      all_red_q <= '0;
      fault_q   <= 1'b0;
      code_q    <= FC_NONE;
      road_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      all_red_q <= all_red_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      road_q    <= road_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_road = road_q;
  assign armed      = (state_q == ST_MONITOR);

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent safety monitor sitting on the light outputs of the traffic light controller. It samples both roads' red/yellow/green drive signals every clock and checks them for illegal patterns, conflicting greens, illegal colour sequences and short phase durations. On the first violation it latches an active-high `fault` and a fault code. `fault` feeds the controller's `fault` input and the board status LEDs.

## Interface
Parameters:
- `TIMER_BITS`, 16: width of every duration counter; all `MIN_*` values must be < 2^TIMER_BITS.
- `MIN_GREEN_CYCLES`, 16: minimum consecutive green samples before green→yellow.
- `MIN_YELLOW_CYCLES`, 8: minimum consecutive yellow samples before yellow→red.
- `MIN_ALL_RED_CYCLES`, 4: minimum consecutive both-red samples before either road goes red→green.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `primaryRoadLight_RYG`  in  3  primary road lights; bit2 = R, bit1 = Y, bit0 = G.
- `secondaryRoadLight_RYG`  in  3  secondary road lights; same encoding.
- `fault_clear`  in  1  single-cycle request to leave FAULT.
- `fault`  out  1  latched violation flag, active-high.
- `fault_code`  out  3  first-violation code; 0 = none.
- `fault_road`  out  1  road of the first violation: 0 = primary, 1 = secondary. For CONFLICT it is 0.
- `armed`  out  1  high while in MONITOR.

## Operation
- States and transitions:
  - ARMING: no checks. Moves to MONITOR on the first sample where both roads equal R (3'b100).
  - MONITOR: all checks active. Moves to FAULT on any violation.
  - FAULT: outputs held. Moves to ARMING when `fault_clear` = 1.
- Per-road checks, applied to every sample in MONITOR:
  - ILLEGAL_PATTERN (code 1): the RYG value is not one-hot.
  - BAD_SEQUENCE (code 3): a colour change other than R→G, G→Y or Y→R.
  - SHORT_GREEN (code 4): a G→Y change when the previous green phase lasted fewer than `MIN_GREEN_CYCLES` samples.
  - SHORT_YELLOW (code 5): a Y→R change when the previous yellow phase lasted fewer than `MIN_YELLOW_CYCLES` samples.
  - SHORT_ALL_RED (code 6): an R→G change when the all-red counter (value at the previous sample) is < `MIN_ALL_RED_CYCLES`.
- Cross-road check: CONFLICT (code 2) when neither road shows exactly R.
- Phase duration = number of consecutive samples showing the same colour. The counter is 1 on the first sample of a phase and saturates at all-ones.
- All-red counter:
  - counts consecutive samples where both roads show R; reset to 0 on any other sample; saturates.
  - Starts at 1 on the sample that arms the monitor.
- Simultaneous violations: the lowest code wins. If the same code fires on both roads, primary wins.
- In FAULT, `fault_code` and `fault_road` hold the first violation. Later violations are ignored.
- `fault_clear` in ARMING or MONITOR is ignored. If `fault_clear` and a new violation arrive together in FAULT, the clear wins.
- Phase counters and last-colour registers run in every state. Checks are gated by state only.

## Timing
- Reset values: `fault` = 0, `fault_code` = 0, `fault_road` = 0, `armed` = 0. State = ARMING; phase and all-red counters = 0; last-colour registers = R.
- Reset is synchronous; asserting it mid-operation (including in FAULT) gives the reset values on the next edge.
- Inputs are registered at the posedge. Response latency is one cycle:
  - Violation in sample n: `fault`, `fault_code` and `fault_road` are valid after edge n+1.
  - Arming: `armed` rises after the edge that sampled both-red.
  - Clear: `fault_clear` sampled at edge n drops `fault` and `fault_code` after edge n+1 and enters ARMING. Re-arming needs a later both-red sample.
- Duration comparisons are unsigned, TIMER_BITS wide, and use the counter value before it restarts.

## Structure
- Shared constants include:
  - RED/YELLOW/GREEN bit indices and one-hot encodings, common with the controller.
  - Monitor state encodings.
  - The six fault-code values.
- Sub-module `traffic_light_phase_tracker`, instantiated once per road.
  - Holds last colour and the saturating phase counter.
  - Outputs: `changed`, `prev_colour`, `prev_duration`, `one_hot_ok`.
- The top level holds the state machine, the all-red counter, the priority encoder and the output registers.

## Test plan
Bench parameters: `MIN_GREEN_CYCLES` = 4, `MIN_YELLOW_CYCLES` = 2, `MIN_ALL_RED_CYCLES` = 2, `TIMER_BITS` = 8.
- Reset, then both R for 3 cycles → `armed` = 1 one cycle after the first both-R sample. Then a legal cycle (primary G ×4, Y ×2, R; both R ×2; secondary G ×4, Y ×2) → `fault` stays 0.
- Armed; primary G held 3 samples, then Y → `fault` = 1, `fault_code` = 4, `fault_road` = 0, one cycle after the Y sample.
- Armed; secondary R→Y directly → code 3, road 1. Then `fault_clear` pulse → `fault` = 0 and `armed` = 0 next cycle. Then both R → `armed` = 1.
- Armed; primary G while secondary 3'b110 in the same sample → code 1 (priority over CONFLICT), road 1.
- Armed; primary Y→R, then secondary R→G after only 1 both-R sample → code 6, road 1. A later both-green sample does not change `fault_code`.
- In MONITOR, assert `reset` for one cycle mid-green → all outputs 0 next cycle. No checks until a both-R sample re-arms the monitor.
